frankie_io_bridge: RTL and testbench

Buffered I/O bridge between the Frankie core's 16-bit I/O port and the outside world. It queues incoming external words with a valid/ready handshake and presents them on the core's `io_in`. It captures core `io_out` writes and drains them to an external consumer. It decouples core instruction timing from external device timing, and its sticky error flags make dropped or missing words visible to the bench.

---
 rtl/frankie_io_pkg.sv | 10 +
 rtl/frankie_io_bridge_if.sv | 35 +++
 rtl/frankie_io_fifo.sv | 68 ++++++
 rtl/frankie_io_bridge.sv | 68 ++++++
 tb/tb_frankie_io_bridge.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/frankie_io_pkg.sv
// Shared widths and typedefs for the Frankie core I/O bridge.
package frankie_io_pkg;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned IO_FIFO_DEPTH = 4;
  localparam int unsigned PTR_W         = $clog2(IO_FIFO_DEPTH);
  localparam int unsigned CNT_W         = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/frankie_io_bridge_if.sv
// Handshake and core-port bundle of the I/O bridge; counts are exported for observation.
interface frankie_io_bridge_if
  import frankie_io_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) ();
  logic [WIDTH-1:0] ext_in_data;
  logic             ext_in_valid;
  logic             ext_in_ready;
  logic [WIDTH-1:0] io_in;
  logic             io_in_avail;
  logic             io_rd;
  logic [WIDTH-1:0] io_out;
  logic             io_wr;
  logic             io_out_full;
  logic [WIDTH-1:0] ext_out_data;
  logic             ext_out_valid;
  logic             ext_out_ready;
  logic             err_ovf;
  logic             err_udf;
  cnt_t             in_count;
  cnt_t             out_count;

  modport master (
    output ext_in_data, ext_in_valid, io_rd, io_out, io_wr, ext_out_ready,
    input  ext_in_ready, io_in, io_in_avail, io_out_full, ext_out_data, ext_out_valid,
    input  err_ovf, err_udf, in_count, out_count
  );

  modport slave (
    input  ext_in_data, ext_in_valid, io_rd, io_out, io_wr, ext_out_ready,
    output ext_in_ready, io_in, io_in_avail, io_out_full, ext_out_data, ext_out_valid,
    output err_ovf, err_udf, in_count, out_count
  );
endinterface

// File: rtl/frankie_io_fifo.sv
// Circular FIFO with registered count; head reads 0 whenever the FIFO is empty.
module frankie_io_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     empty,
  output logic                     full,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/frankie_io_bridge.sv
// Buffered bridge between the Frankie core I/O port and external valid/ready streams.
module frankie_io_bridge
  import frankie_io_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = IO_FIFO_DEPTH
) (
  input  logic                clock,
  input  logic                reset,
  frankie_io_bridge_if.slave  bus
);
  logic in_push, in_pop, in_empty, in_full;
  logic out_push, out_pop, out_empty, out_full;
  logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

  // Ready is held low during reset so no handshake completes on a reset edge.
  assign bus.ext_in_ready  = ~in_full & reset;
  assign in_push           = bus.ext_in_valid & bus.ext_in_ready;
  assign in_pop            = bus.io_rd & ~in_empty;
  assign out_push          = bus.io_wr & ~out_full;
  assign out_pop           = ~out_empty & bus.ext_out_ready;

  assign bus.io_in_avail   = ~in_empty;
  assign bus.io_out_full   = out_full;
  assign bus.ext_out_valid = ~out_empty;
  assign bus.err_ovf       = err_ovf_q;
  assign bus.err_udf       = err_udf_q;

  frankie_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_push),
    .pop   (in_pop),
    .wdata (bus.ext_in_data),
    .empty (in_empty),
    .full  (in_full),
    .head  (bus.io_in),
    .count (bus.in_count)
  );

  frankie_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (bus.io_out),
    .empty (out_empty),
    .full  (out_full),
    .head  (bus.ext_out_data),
    .count (bus.out_count)
  );

  // Sticky error flags, cleared only by reset.
  always_comb begin
    err_ovf_d = err_ovf_q | (bus.io_wr & out_full);
    err_udf_d = err_udf_q | (bus.io_rd & in_empty);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end
endmodule

// File: tb/tb_frankie_io_bridge.sv
// Directed self-checking bench for frankie_io_bridge.
module tb_frankie_io_bridge;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  frankie_io_bridge_if bus ();

  frankie_io_bridge dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.ext_in_data = '0; bus.ext_in_valid = 1'b0; bus.io_rd = 1'b0;
    bus.io_out = '0; bus.io_wr = 1'b0; bus.ext_out_ready = 1'b0;
    reset = 1'b0;
    repeat (3) cyc();
    vectors++; if (bus.io_in !== 16'd0 || bus.io_in_avail !== 1'b0) begin miscompares++;
      $display("FAIL reset_in io_in=%0d avail=%b want 0/0", bus.io_in, bus.io_in_avail); end
    vectors++; if (bus.ext_out_valid !== 1'b0 || bus.ext_out_data !== 16'd0 || bus.io_out_full !== 1'b0) begin miscompares++;
      $display("FAIL reset_out valid=%b data=%0d full=%b want 0/0/0", bus.ext_out_valid, bus.ext_out_data, bus.io_out_full); end
    vectors++; if (bus.ext_in_ready !== 1'b0 || bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin miscompares++;
      $display("FAIL reset_flags ready=%b ovf=%b udf=%b want 0/0/0", bus.ext_in_ready, bus.err_ovf, bus.err_udf); end
    reset = 1'b1;
    #1;
    vectors++; if (bus.ext_in_ready !== 1'b1) begin miscompares++;
      $display("FAIL release_ready got %b want 1", bus.ext_in_ready); end
  endtask

  task automatic test_single_word();
    bus.ext_in_data = 16'd16; bus.ext_in_valid = 1'b1;
    cyc();
    bus.ext_in_valid = 1'b0;
    vectors++; if (bus.io_in !== 16'd16 || bus.io_in_avail !== 1'b1) begin miscompares++;
      $display("FAIL single_push io_in=%0d avail=%b want 16/1", bus.io_in, bus.io_in_avail); end
    bus.io_rd = 1'b1;
    cyc();
    bus.io_rd = 1'b0;
    vectors++; if (bus.io_in !== 16'd0 || bus.io_in_avail !== 1'b0 || bus.err_udf !== 1'b0) begin miscompares++;
      $display("FAIL single_pop io_in=%0d avail=%b udf=%b want 0/0/0", bus.io_in, bus.io_in_avail, bus.err_udf); end
  endtask

  task automatic test_input_fill();
    for (int i = 1; i <= 4; i++) begin
      bus.ext_in_data = 16'(i); bus.ext_in_valid = 1'b1;
      cyc();
    end
    vectors++; if (bus.ext_in_ready !== 1'b0 || bus.in_count !== 3'd4) begin miscompares++;
      $display("FAIL fill_full ready=%b count=%0d want 0/4", bus.ext_in_ready, bus.in_count); end
    bus.ext_in_data = 16'd5;
    cyc();
    bus.ext_in_valid = 1'b0;
    vectors++; if (bus.in_count !== 3'd4 || bus.io_in !== 16'd1) begin miscompares++;
      $display("FAIL fill_fifth count=%0d head=%0d want 4/1", bus.in_count, bus.io_in); end
    for (int i = 1; i <= 4; i++) begin
      vectors++; if (bus.io_in !== 16'(i)) begin miscompares++;
        $display("FAIL fill_pop%0d got %0d want %0d", i, bus.io_in, i); end
      bus.io_rd = 1'b1;
      cyc();
      bus.io_rd = 1'b0;
    end
    vectors++; if (bus.io_in_avail !== 1'b0 || bus.ext_in_ready !== 1'b1 || bus.err_udf !== 1'b0) begin miscompares++;
      $display("FAIL fill_empty avail=%b ready=%b udf=%b want 0/1/0", bus.io_in_avail, bus.ext_in_ready, bus.err_udf); end
  endtask

  task automatic test_out_backpressure();
    bus.ext_out_ready = 1'b0;
    bus.io_out = 16'd7; bus.io_wr = 1'b1;
    cyc();
    bus.io_out = 16'd2;
    cyc();
    bus.io_wr = 1'b0;
    cyc();
    vectors++; if (bus.ext_out_valid !== 1'b1 || bus.ext_out_data !== 16'd7 || bus.out_count !== 3'd2) begin miscompares++;
      $display("FAIL bp_hold valid=%b data=%0d count=%0d want 1/7/2", bus.ext_out_valid, bus.ext_out_data, bus.out_count); end
    bus.ext_out_ready = 1'b1;
    cyc();
    vectors++; if (bus.ext_out_valid !== 1'b1 || bus.ext_out_data !== 16'd2) begin miscompares++;
      $display("FAIL bp_second valid=%b data=%0d want 1/2", bus.ext_out_valid, bus.ext_out_data); end
    cyc();
    bus.ext_out_ready = 1'b0;
    vectors++; if (bus.ext_out_valid !== 1'b0 || bus.ext_out_data !== 16'd0) begin miscompares++;
      $display("FAIL bp_drained valid=%b data=%0d want 0/0", bus.ext_out_valid, bus.ext_out_data); end
  endtask

  task automatic test_overflow();
    for (int i = 10; i <= 13; i++) begin
      bus.io_out = 16'(i); bus.io_wr = 1'b1;
      cyc();
    end
    vectors++; if (bus.io_out_full !== 1'b1 || bus.err_ovf !== 1'b0) begin miscompares++;
      $display("FAIL ovf_full full=%b ovf=%b want 1/0", bus.io_out_full, bus.err_ovf); end
    bus.io_out = 16'd99;
    cyc();
    vectors++; if (bus.err_ovf !== 1'b1 || bus.out_count !== 3'd4 || bus.ext_out_data !== 16'd10) begin miscompares++;
      $display("FAIL ovf_drop ovf=%b count=%0d head=%0d want 1/4/10", bus.err_ovf, bus.out_count, bus.ext_out_data); end
    // Write at full while draining: the write is blocked, only the pop happens.
    bus.io_out = 16'd77; bus.ext_out_ready = 1'b1;
    cyc();
    bus.io_wr = 1'b0;
    vectors++; if (bus.out_count !== 3'd3 || bus.ext_out_data !== 16'd11) begin miscompares++;
      $display("FAIL ovf_pushpop count=%0d head=%0d want 3/11", bus.out_count, bus.ext_out_data); end
    for (int i = 11; i <= 13; i++) begin
      vectors++; if (bus.ext_out_valid !== 1'b1 || bus.ext_out_data !== 16'(i)) begin miscompares++;
        $display("FAIL ovf_drain%0d valid=%b data=%0d want 1/%0d", i, bus.ext_out_valid, bus.ext_out_data, i); end
      cyc();
    end
    bus.ext_out_ready = 1'b0;
    vectors++; if (bus.ext_out_valid !== 1'b0 || bus.err_ovf !== 1'b1) begin miscompares++;
      $display("FAIL ovf_end valid=%b ovf=%b want 0/1", bus.ext_out_valid, bus.err_ovf); end
  endtask

  task automatic test_underflow_wrap();
    logic [15:0] seq [6];
    seq[0] = 16'd55; seq[1] = 16'd5;  seq[2] = 16'd50;
    seq[3] = 16'd45; seq[4] = 16'd40; seq[5] = 16'd35;
    bus.io_rd = 1'b1;
    cyc();
    bus.io_rd = 1'b0;
    vectors++; if (bus.err_udf !== 1'b1 || bus.io_in !== 16'd0 || bus.in_count !== 3'd0) begin miscompares++;
      $display("FAIL udf_flag udf=%b io_in=%0d count=%0d want 1/0/0", bus.err_udf, bus.io_in, bus.in_count); end
    // Push and pop on empty: pop ignored, push stored.
    bus.ext_in_data = seq[0]; bus.ext_in_valid = 1'b1; bus.io_rd = 1'b1;
    cyc();
    vectors++; if (bus.io_in !== seq[0] || bus.in_count !== 3'd1) begin miscompares++;
      $display("FAIL wrap_first io_in=%0d count=%0d want %0d/1", bus.io_in, bus.in_count, seq[0]); end
    for (int i = 1; i < 6; i++) begin
      bus.ext_in_data = seq[i];
      cyc();
      vectors++; if (bus.io_in !== seq[i] || bus.in_count !== 3'd1) begin miscompares++;
        $display("FAIL wrap_%0d io_in=%0d count=%0d want %0d/1", i, bus.io_in, bus.in_count, seq[i]); end
    end
    bus.ext_in_valid = 1'b0;
    cyc();
    bus.io_rd = 1'b0;
    vectors++; if (bus.io_in_avail !== 1'b0 || bus.in_count !== 3'd0) begin miscompares++;
      $display("FAIL wrap_end avail=%b count=%0d want 0/0", bus.io_in_avail, bus.in_count); end
  endtask

  task automatic test_mid_reset();
    bus.ext_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ext_in_data = 16'hA1 + 16'(i); bus.ext_in_valid = 1'b1;
      bus.io_out = 16'hB1 + 16'(i); bus.io_wr = 1'b1;
      cyc();
    end
    bus.ext_in_valid = 1'b0; bus.io_wr = 1'b0;
    vectors++; if (bus.in_count !== 3'd3 || bus.out_count !== 3'd3 || bus.io_in !== 16'hA1 || bus.ext_out_data !== 16'hB1) begin miscompares++;
      $display("FAIL mid_queued in=%0d out=%0d io_in=%h ext=%h want 3/3/a1/b1", bus.in_count, bus.out_count, bus.io_in, bus.ext_out_data); end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (bus.io_in !== 16'd0 || bus.io_in_avail !== 1'b0 || bus.ext_out_valid !== 1'b0 || bus.ext_out_data !== 16'd0) begin miscompares++;
      $display("FAIL mid_async io_in=%0d avail=%b valid=%b data=%0d want 0/0/0/0", bus.io_in, bus.io_in_avail, bus.ext_out_valid, bus.ext_out_data); end
    vectors++; if (bus.ext_in_ready !== 1'b0 || bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin miscompares++;
      $display("FAIL mid_flags ready=%b ovf=%b udf=%b want 0/0/0", bus.ext_in_ready, bus.err_ovf, bus.err_udf); end
    cyc();
    reset = 1'b1;
    cyc();
    vectors++; if (bus.in_count !== 3'd0 || bus.out_count !== 3'd0 || bus.ext_in_ready !== 1'b1) begin miscompares++;
      $display("FAIL mid_release in=%0d out=%0d ready=%b want 0/0/1", bus.in_count, bus.out_count, bus.ext_in_ready); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_input_fill();
    test_out_backpressure();
    test_overflow();
    test_underflow_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
